serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per clock, LSB first, WIDTH+1 cycles per operation.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' port).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    always_comb begin
        w_s = r_a[0] ^ r_b[0] ^ r_c;
        w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
`ifdef SERIAL_ADDER_SUB_EN
        // a - b computed as a + ~b + 1; cout then reads as "no borrow"
        w_b_load = sub ? ~b : b;
        w_c_load = sub ? 1'b1 : cin;
`else
        w_b_load = b;
        w_c_load = cin;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_c     <= w_c_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a    <= {1'b0, r_a[WIDTH-1:1]};
                    r_b    <= {1'b0, r_b[WIDTH-1:1]};
                    r_psum <= {w_s, r_psum[WIDTH-1:1]};
                    r_c    <= w_c;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // final bit goes straight into the result alongside the shift
                        r_sum   <= {w_s, r_psum[WIDTH-1:1]};
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
